// File: rtl/battery_monitor_ctrl.sv
// Battery monitor sequencer.
// Takes turns sampling both batteries on the shared 4-bit ADC and forms the
// registered 5-bit sum that feeds the level comparator. The sum is classified
// into one of five levels, the level is debounced over consecutive rounds, and
// a blinking alarm is raised while the level is critical.
module battery_monitor_ctrl #(
    parameter int SAMPLE_PERIOD = 1000,
    parameter int STABLE_COUNT  = 4,
    parameter int TIMEOUT       = 255,
    parameter int BLINK_HALF    = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    output logic       adc_req,
    output logic       adc_sel,
    input  logic       adc_valid,
    input  logic [3:0] adc_data,
    output logic [4:0] sum_out,
    output logic       sum_valid,
    output logic [2:0] level,
    output logic       level_valid,
    output logic       level_changed,
    output logic       alarm,
    output logic       adc_fault,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ1 = 3'd1,
        ST_REQ2 = 3'd2,
        ST_SUM  = 3'd3,
        ST_EVAL = 3'd4
    } state_t;

    // Counter widths: each counter runs 0 .. LIMIT-1 (run counter 0 .. STABLE_COUNT)
    localparam int IDLE_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int BLNK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int CNT_W  = $clog2(STABLE_COUNT + 1);

    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(SAMPLE_PERIOD - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [BLNK_W-1:0] BLNK_LAST = BLNK_W'(BLINK_HALF - 1);
    localparam logic [BLNK_W-1:0] BLNK_ONE  = BLNK_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STABLE_COUNT);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    // Map a battery sum onto its level code: critical/low/medium/high/full
    function automatic logic [2:0] classify(input logic [4:0] s);
        logic [2:0] c;
        if (s < 5'd3) begin
            c = 3'd0;
        end else if (s < 5'd10) begin
            c = 3'd1;
        end else if (s < 5'd19) begin
            c = 3'd2;
        end else if (s < 5'd30) begin
            c = 3'd3;
        end else begin
            c = 3'd4;
        end
        return c;
    endfunction

    state_t            state_r;
    logic [IDLE_W-1:0] idle_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [3:0]        b1_r;
    logic [3:0]        b2_r;
    logic [2:0]        cand_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [BLNK_W-1:0] blink_cnt_r;
    logic              blink_run_r;
    logic [4:0]        sum_next_s;
    logic [2:0]        class_next_s;
    logic              critical_s;

    // Sum of the two captured samples and its classification
    always_comb begin
        sum_next_s   = {1'b0, b1_r} + {1'b0, b2_r};
        class_next_s = classify(sum_next_s);
        critical_s   = level_valid && (level == 3'd0);
    end

    // ADC handshake and busy flag decoded straight from the state register
    always_comb begin
        adc_req = 1'b0;
        adc_sel = 1'b0;
        busy    = 1'b1;
        case (state_r)
            ST_IDLE: busy = 1'b0;
            ST_REQ1: adc_req = 1'b1;
            ST_REQ2: begin
                adc_req = 1'b1;
                adc_sel = 1'b1;
            end
            ST_SUM:  busy = 1'b1;
            ST_EVAL: busy = 1'b1;
            default: busy = 1'b1;
        endcase
    end

    // Measurement sequencer: idle wait, two ADC requests, sum, debounce evaluation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            idle_cnt_r    <= '0;
            wait_cnt_r    <= '0;
            b1_r          <= 4'd0;
            b2_r          <= 4'd0;
            cand_r        <= 3'd0;
            cnt_r         <= '0;
            sum_out       <= 5'd0;
            sum_valid     <= 1'b0;
            level         <= 3'd0;
            level_valid   <= 1'b0;
            level_changed <= 1'b0;
            adc_fault     <= 1'b0;
        end else begin
            sum_valid     <= 1'b0;
            level_changed <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (idle_cnt_r == IDLE_LAST) begin
                        idle_cnt_r <= '0;
                        wait_cnt_r <= '0;
                        state_r    <= ST_REQ1;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + IDLE_ONE;
                    end
                end
                ST_REQ1: begin
                    if (adc_valid) begin
                        b1_r       <= adc_data;
                        wait_cnt_r <= '0;
                        state_r    <= ST_REQ2;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        adc_fault  <= 1'b1;
                        idle_cnt_r <= '0;
                        state_r    <= ST_IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                    end
                end
                ST_REQ2: begin
                    if (adc_valid) begin
                        b2_r    <= adc_data;
                        state_r <= ST_SUM;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        adc_fault  <= 1'b1;
                        idle_cnt_r <= '0;
                        state_r    <= ST_IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                    end
                end
                ST_SUM: begin
                    sum_out   <= sum_next_s;
                    sum_valid <= 1'b1;
                    adc_fault <= 1'b0;
                    if (class_next_s == cand_r) begin
                        if (cnt_r != CNT_MAX) begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end else begin
                            cnt_r <= cnt_r;
                        end
                    end else begin
                        cand_r <= class_next_s;
                        cnt_r  <= CNT_ONE;
                    end
                    state_r <= ST_EVAL;
                end
                ST_EVAL: begin
                    if ((cnt_r == CNT_MAX) && (!level_valid || (cand_r != level))) begin
                        level         <= cand_r;
                        level_valid   <= 1'b1;
                        level_changed <= 1'b1;
                    end else begin
                        level_changed <= 1'b0;
                    end
                    idle_cnt_r <= '0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    idle_cnt_r <= '0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    // Critical alarm blinker: high on the cycle after entering critical, then toggles
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm       <= 1'b0;
            blink_cnt_r <= '0;
            blink_run_r <= 1'b0;
        end else if (!critical_s) begin
            alarm       <= 1'b0;
            blink_cnt_r <= '0;
            blink_run_r <= 1'b0;
        end else if (!blink_run_r) begin
            alarm       <= 1'b1;
            blink_cnt_r <= '0;
            blink_run_r <= 1'b1;
        end else if (blink_cnt_r == BLNK_LAST) begin
            alarm       <= ~alarm;
            blink_cnt_r <= '0;
        end else begin
            blink_cnt_r <= blink_cnt_r + BLNK_ONE;
        end
    end

endmodule

// File: tb/tb_battery_monitor_ctrl.sv
// Self-checking bench for battery_monitor_ctrl with small parameters.
// The reference keeps a history of per-round classes and declares a level
// stable once the most recent rounds all agree.
module tb_battery_monitor_ctrl;

    localparam int P = 4;
    localparam int S = 2;
    localparam int T = 8;
    localparam int B = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       adc_valid = 1'b0;
    logic [3:0] adc_data = 4'd0;
    logic       adc_req;
    logic       adc_sel;
    logic [4:0] sum_out;
    logic       sum_valid;
    logic [2:0] level;
    logic       level_valid;
    logic       level_changed;
    logic       alarm;
    logic       adc_fault;
    logic       busy;

    battery_monitor_ctrl #(
        .SAMPLE_PERIOD(P),
        .STABLE_COUNT (S),
        .TIMEOUT      (T),
        .BLINK_HALF   (B)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .adc_req      (adc_req),
        .adc_sel      (adc_sel),
        .adc_valid    (adc_valid),
        .adc_data     (adc_data),
        .sum_out      (sum_out),
        .sum_valid    (sum_valid),
        .level        (level),
        .level_valid  (level_valid),
        .level_changed(level_changed),
        .alarm        (alarm),
        .adc_fault    (adc_fault),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int chg_cnt = 0;

    // reference model state
    int hist[$];
    int exp_level = 0;
    bit exp_lv = 1'b0;

    always @(posedge clk) begin
        if (level_changed === 1'b1) chg_cnt++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int class_of(input int s);
        if (s < 3) return 0;
        if (s <= 9) return 1;
        if (s <= 18) return 2;
        if (s <= 29) return 3;
        return 4;
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic model_reset;
        hist.delete();
        exp_level = 0;
        exp_lv = 1'b0;
    endtask

    // Returns 1 if the newest round made the level change
    task automatic model_round(input int s, output bit changed);
        int c;
        bit same;
        c = class_of(s);
        hist.push_back(c);
        changed = 1'b0;
        if (hist.size() >= S) begin
            same = 1'b1;
            for (int k = 0; k < S; k++) begin
                if (hist[hist.size() - 1 - k] != c) same = 1'b0;
            end
            if (same && (!exp_lv || exp_level != c)) begin
                exp_level = c;
                exp_lv = 1'b1;
                changed = 1'b1;
            end
        end
    endtask

    task automatic wait_req(input bit sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (adc_req === 1'b1 && adc_sel === sel) begin
                ok = 1'b1;
                break;
            end
            if (adc_req !== 1'b1) begin
                adc_valid = ($urandom_range(0, 3) == 0);
                adc_data = 4'($urandom);
            end else begin
                adc_valid = 1'b0;
            end
            tick();
        end
        adc_valid = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL wait_req: adc_req with sel=%0d not seen within 60 cycles", sel);
        end
    endtask

    task automatic do_round(input logic [3:0] d1, input logic [3:0] d2, input int lat1, input int lat2);
        bit ok;
        bit exp_chg;
        int exp_sum;
        wait_req(1'b0, ok);
        if (!ok) return;
        repeat (lat1 - 1) tick();
        adc_valid = 1'b1; adc_data = d1;
        tick();
        adc_valid = 1'b0; adc_data = 4'($urandom);
        n_cmp++;
        if (adc_req !== 1'b1 || adc_sel !== 1'b1) begin
            n_err++;
            $display("FAIL req2_enter: req=%b sel=%b, want req=1 sel=1", adc_req, adc_sel);
        end
        repeat (lat2 - 1) tick();
        adc_valid = 1'b1; adc_data = d2;
        tick();
        adc_valid = 1'b0; adc_data = 4'($urandom);
        n_cmp++;
        if (sum_valid !== 1'b0 || busy !== 1'b1 || adc_req !== 1'b0) begin
            n_err++;
            $display("FAIL sum_state: sum_valid=%b busy=%b req=%b, want 0 1 0", sum_valid, busy, adc_req);
        end
        tick();
        exp_sum = int'(d1) + int'(d2);
        n_cmp++;
        if (sum_valid !== 1'b1 || sum_out !== 5'(exp_sum) || adc_fault !== 1'b0) begin
            n_err++;
            $display("FAIL sum_out: valid=%b sum=%0d fault=%b, want 1 %0d 0", sum_valid, sum_out, adc_fault, exp_sum);
        end
        model_round(exp_sum, exp_chg);
        tick();
        n_cmp++;
        if (sum_valid !== 1'b0 || level !== 3'(exp_level) || level_valid !== exp_lv ||
            level_changed !== exp_chg || busy !== 1'b0) begin
            n_err++;
            $display("FAIL level_update: sv=%b lvl=%0d lv=%b chg=%b busy=%b, want 0 %0d %b %b 0",
                     sum_valid, level, level_valid, level_changed, busy, exp_level, exp_lv, exp_chg);
        end
    endtask

    task automatic do_timeout(input logic [3:0] d1, input int lat1);
        bit ok;
        logic [4:0] prev_sum;
        wait_req(1'b0, ok);
        if (!ok) return;
        repeat (lat1 - 1) tick();
        prev_sum = sum_out;
        adc_valid = 1'b1; adc_data = d1;
        tick();
        adc_valid = 1'b0;
        repeat (T - 1) tick();
        n_cmp++;
        if (adc_req !== 1'b1 || adc_sel !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_last_wait: req=%b sel=%b, want 1 1", adc_req, adc_sel);
        end
        tick();
        n_cmp++;
        if (adc_req !== 1'b0 || adc_fault !== 1'b1 || sum_valid !== 1'b0 || busy !== 1'b0 ||
            sum_out !== prev_sum || level !== 3'(exp_level) || level_valid !== exp_lv) begin
            n_err++;
            $display("FAIL timeout: req=%b fault=%b sv=%b busy=%b sum=%0d lvl=%0d lv=%b, want 0 1 0 0 %0d %0d %b",
                     adc_req, adc_fault, sum_valid, busy, sum_out, level, level_valid,
                     prev_sum, exp_level, exp_lv);
        end
    endtask

    // Hold reset, check outputs, release and check the first request lands P cycles later
    task automatic test_reset;
        rst = 1'b1; adc_valid = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({adc_req, adc_sel, sum_out, sum_valid, level, level_valid, level_changed,
             alarm, adc_fault, busy} !== 16'd0) begin
            n_err++;
            $display("FAIL reset_outputs: req=%b sel=%b sum=%0d sv=%b lvl=%0d lv=%b chg=%b al=%b flt=%b busy=%b, want all 0",
                     adc_req, adc_sel, sum_out, sum_valid, level, level_valid, level_changed, alarm, adc_fault, busy);
        end
        rst = 1'b0;
        model_reset();
        for (int n = 1; n <= P; n++) begin
            tick();
            n_cmp++;
            if (adc_req !== (n == P) || busy !== (n == P)) begin
                n_err++;
                $display("FAIL first_req: cycle %0d req=%b busy=%b, want %b", n, adc_req, busy, (n == P));
            end
        end
    endtask

    task automatic test_basic;
        int c0;
        c0 = chg_cnt;
        do_round(4'd7, 4'd8, 1, 1);
        do_round(4'd7, 4'd8, 1, 1);
        tick();
        n_cmp++;
        if (chg_cnt - c0 != 1 || level !== 3'd2 || level_valid !== 1'b1) begin
            n_err++;
            $display("FAIL basic_level: changes=%0d lvl=%0d lv=%b, want 1 2 1", chg_cnt - c0, level, level_valid);
        end
    endtask

    task automatic test_boundary;
        logic [3:0] a [8] = '{4'd1, 4'd0, 4'd9, 4'd5, 4'd9, 4'd10, 4'd15, 4'd15};
        logic [3:0] b [8] = '{4'd1, 4'd3, 4'd0, 4'd5, 4'd9, 4'd9,  4'd14, 4'd15};
        for (int i = 0; i < 8; i++) begin
            do_round(a[i], b[i], 1, 2);
            do_round(a[i], b[i], 2, 1);
        end
    endtask

    task automatic test_debounce;
        int c0;
        test_reset();
        c0 = chg_cnt;
        do_round(4'd15, 4'd15, 1, 1);
        do_round(4'd15, 4'd15, 1, 1);
        do_round(4'd10, 4'd10, 1, 1);
        do_round(4'd15, 4'd15, 1, 1);
        do_round(4'd15, 4'd15, 1, 1);
        tick();
        n_cmp++;
        if (chg_cnt - c0 != 1 || level !== 3'd4) begin
            n_err++;
            $display("FAIL debounce: changes=%0d lvl=%0d, want 1 4", chg_cnt - c0, level);
        end
    endtask

    task automatic test_timeout;
        bit ok;
        do_timeout(4'd6, T - 2);
        wait_req(1'b0, ok);
        n_cmp++;
        if (adc_fault !== 1'b1) begin
            n_err++;
            $display("FAIL fault_sticky: fault=%b, want 1", adc_fault);
        end
        do_round(4'd3, 4'd2, 1, 1);
    endtask

    task automatic test_alarm;
        test_reset();
        do_round(4'd1, 4'd0, 1, 1);
        do_round(4'd1, 4'd0, 1, 1);
        n_cmp++;
        if (alarm !== 1'b0 || level !== 3'd0 || level_valid !== 1'b1) begin
            n_err++;
            $display("FAIL alarm_entry: alarm=%b lvl=%0d lv=%b, want 0 0 1", alarm, level, level_valid);
        end
        for (int i = 0; i < 7; i++) begin
            tick();
            n_cmp++;
            if (alarm !== (((i / B) % 2) == 0)) begin
                n_err++;
                $display("FAIL alarm_blink: step %0d alarm=%b, want %b", i, alarm, (((i / B) % 2) == 0));
            end
        end
        do_round(4'd5, 4'd5, 1, 1);
        do_round(4'd5, 4'd5, 1, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (alarm !== 1'b0) begin
                n_err++;
                $display("FAIL alarm_off: step %0d alarm=%b, want 0", i, alarm);
            end
        end
    endtask

    task automatic test_reset_mid_round;
        bit ok;
        do_round(4'd15, 4'd15, 1, 1);
        do_round(4'd15, 4'd15, 1, 1);
        wait_req(1'b0, ok);
        adc_valid = 1'b1; adc_data = 4'd12;
        tick();
        rst = 1'b1; adc_valid = 1'b1; adc_data = 4'd15;
        tick();
        adc_valid = 1'b0;
        n_cmp++;
        if ({adc_req, adc_sel, sum_out, sum_valid, level, level_valid, level_changed,
             alarm, adc_fault, busy} !== 16'd0) begin
            n_err++;
            $display("FAIL reset_mid: req=%b sel=%b sum=%0d sv=%b lvl=%0d lv=%b chg=%b al=%b flt=%b busy=%b, want all 0",
                     adc_req, adc_sel, sum_out, sum_valid, level, level_valid, level_changed, alarm, adc_fault, busy);
        end
        rst = 1'b0;
        model_reset();
        for (int n = 1; n <= P; n++) begin
            tick();
            n_cmp++;
            if (adc_req !== (n == P)) begin
                n_err++;
                $display("FAIL reset_mid_req: cycle %0d req=%b, want %b", n, adc_req, (n == P));
            end
        end
        do_round(4'd3, 4'd4, 1, 1);
    endtask

    task automatic test_random;
        logic [3:0] pa [4] = '{4'd1, 4'd6, 4'd12, 4'd15};
        logic [3:0] pb [4] = '{4'd0, 4'd7, 4'd4,  4'd15};
        int sel;
        sel = 0;
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 7) == 0) begin
                do_timeout(4'($urandom), int'($urandom_range(1, 4)));
            end else begin
                if ($urandom_range(0, 2) == 0) sel = int'($urandom_range(0, 3));
                if ($urandom_range(0, 5) == 0)
                    do_round(4'($urandom), 4'($urandom), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
                else
                    do_round(pa[sel], pb[sel], int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_boundary();
        test_debounce();
        test_timeout();
        test_alarm();
        test_reset_mid_round();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
